fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC and drives the memory's byte address. The memory returns a 16-bit instruction combinationally, indexed by addr[31:2], so one instruction per 4-byte step.
- Buffers fetched instructions with their PCs in a small FIFO toward decode, with a valid/ready handshake.
- Supports branch redirect with flush, and a HALT opcode that stops fetching.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  fq_entry_t               wdata_i,
  output fq_entry_t               head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // A push at full is legal only because the head slot frees up on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fills the fetch queue from imem, handles redirect and HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FQ_DEPTH    = 4,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [15:0]                imem_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [15:0]                dec_instr,
  output logic [31:0]                dec_pc,
  output logic                       halted,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             push, pop, fq_full, fq_empty;
  fq_entry_t        fq_head, fq_wdata;

  assign imem_addr = pc_q;
  assign dec_valid = ~fq_empty;
  assign dec_instr = fq_head.instr;
  assign dec_pc    = fq_head.pc;
  assign halted    = (state_q == HALTED);

  assign pop  = dec_valid & dec_ready;
  assign push = (state_q == RUN) & ~redirect_valid & (~fq_full | pop);

  assign fq_wdata.instr = imem_instr;
  assign fq_wdata.pc    = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = RUN;
    end else if (push) begin
      pc_d = pc_q + 32'(PC_STEP);
      if (imem_instr == HALT_OPCODE) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect flushes the queue; any coincident pop is dropped with it.
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (fq_wdata),
    .head_o  (fq_head),
    .count_o (fq_count),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [15:0] dec_instr;
  logic [31:0] dec_pc;
  logic        halted;
  logic [2:0]  fq_count;

  logic [15:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(4), .HALT_OPCODE(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .halted(halted), .fq_count(fq_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1001 + 16'(i);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_count", 32'(fq_count), 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc",    dec_pc, 0);
    chk("rst_instr", 32'(dec_instr), 0);
    tick();
    rst = 1'b0;

    // Streaming: one instruction per cycle, first valid after the first edge.
    chk("s_addr0", imem_addr, 0);
    chk("s_valid0", 32'(dec_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s_addr",  imem_addr, 32'(4*(k+1)));
      chk("s_valid", 32'(dec_valid), 1);
      chk("s_pc",    dec_pc, 32'(4*k));
      chk("s_instr", 32'(dec_instr), 32'(16'h1001 + 16'(k)));
      chk("s_count", 32'(fq_count), 1);
    end

    // Backpressure: fill to 4, PC holds at 16, then drain in order at full rate.
    do_reset();
    dec_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("bp_count", 32'(fq_count), 4);
    chk("bp_addr",  imem_addr, 16);
    chk("bp_head",  dec_pc, 0);
    dec_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("full_pc",    dec_pc, 32'(4*k));
      chk("full_instr", 32'(dec_instr), 32'(16'h1001 + 16'(k)));
      chk("full_count", 32'(fq_count), 4);
      chk("full_addr",  imem_addr, 32'(16 + 4*k));
    end

    // Redirect with 3 queued entries and a concurrent handshake.
    do_reset();
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("rd_pre_count", 32'(fq_count), 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    dec_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rd_count", 32'(fq_count), 0);
    chk("rd_addr",  imem_addr, 32'h100);
    chk("rd_valid", 32'(dec_valid), 0);
    tick();
    chk("rd_pc",    dec_pc, 32'h100);
    chk("rd_instr", 32'(dec_instr), 32'(16'h1001 + 16'd64));
    chk("rd_addr2", imem_addr, 32'h104);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr2", imem_addr, 0);
    chk("wr_pc", dec_pc, 32'hFFFF_FFFC);

    // HALT at PC 8.
    mem[2] = 16'hFFFF;
    do_reset();
    dec_ready = 1'b1;
    tick();
    tick();
    chk("h_run", 32'(halted), 0);
    tick();
    chk("h_pc",     dec_pc, 8);
    chk("h_instr",  32'(dec_instr), 32'hFFFF);
    chk("h_halted", 32'(halted), 1);
    chk("h_addr",   imem_addr, 12);
    tick();
    chk("h_drain",  32'(dec_valid), 0);
    tick();
    chk("h_frozen", imem_addr, 12);
    chk("h_novalid", 32'(dec_valid), 0);
    chk("h_count",  32'(fq_count), 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("h_resume", 32'(halted), 0);
    chk("h_raddr",  imem_addr, 32'h40);
    tick();
    chk("h_rpc",    dec_pc, 32'h40);
    chk("h_rinstr", 32'(dec_instr), 32'(16'h1001 + 16'd16));
    mem[2] = 16'h1003;

    // Async reset between edges.
    dec_ready = 1'b0;
    tick();
    tick();
    chk("ar_pre", 32'(fq_count), 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(dec_valid), 0);
    chk("ar_count", 32'(fq_count), 0);
    chk("ar_addr",  imem_addr, 0);
    tick();
    rst = 1'b0;
    dec_ready = 1'b1;
    tick();
    chk("ar_pc",    dec_pc, 0);
    chk("ar_instr", 32'(dec_instr), 32'h1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
